// File: rtl/m_dmux8way_buf.sv
// m_dmux8way_buf: registered 1-to-8 word demux, one-entry buffer per channel, valid/ready on both sides
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_data   upstream word, routed to channel i_sel
//   i_sel    destination channel 0..7
//   i_valid  upstream word present
//   o_ready  upstream word can be taken this cycle (combinational in i_sel, i_ready)
//   o_data   channel k word on bits [k*WIDTH +: WIDTH]
//   o_valid  bit k: channel k buffer holds a word
//   i_ready  bit k: consumer k takes its word this cycle
//   o_count  words accepted since reset, wraps at 2^16
module m_dmux8way_buf #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [2:0]         i_sel,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [8*WIDTH-1:0] o_data,
    output logic [7:0]         o_valid,
    input  logic [7:0]         i_ready,
    output logic [15:0]        o_count
);
    logic [7:0]       full;
    logic [WIDTH-1:0] word [8];
    logic             accept;

    // a full channel still accepts when its consumer drains in the same cycle
    assign o_ready = ~full[i_sel] | i_ready[i_sel];
    assign accept  = i_valid & o_ready;
    assign o_valid = full;

    for (genvar g = 0; g < 8; g++) begin : g_out
        assign o_data[g*WIDTH +: WIDTH] = word[g];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            full    <= '0;
            o_count <= '0;
            for (int k = 0; k < 8; k++) word[k] <= '0;
        end else begin
            if (accept) o_count <= o_count + 16'd1;
            for (int k = 0; k < 8; k++) begin
                if (accept && i_sel == 3'(k)) begin
                    word[k] <= i_data;
                    full[k] <= 1'b1;
                end else if (full[k] && i_ready[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_m_dmux8way_buf.sv
// tb_m_dmux8way_buf: scoreboard bench for m_dmux8way_buf with directed vectors
module tb_m_dmux8way_buf;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  data = '0;
    logic [2:0]   sel = '0;
    logic         valid = 1'b0;
    logic         o_ready;
    logic [127:0] o_data;
    logic [7:0]   o_valid;
    logic [7:0]   ready = '0;
    logic [15:0]  o_count;

    int total = 0;
    int bad = 0;

    logic [15:0] q [8][$];
    logic [7:0]  mfull = '0;
    logic [7:0]  nfull = '0;
    logic        armed = 1'b0;

    m_dmux8way_buf #(.WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_sel(sel), .i_valid(valid),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(ready), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: compares handshake state and pops the expected word whenever a consumer takes one
    always @(negedge clk) begin
        logic        er;
        logic [15:0] w;
        if (armed) begin
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) q[k].delete();
                nfull = '0;
            end else begin
                er = !mfull[sel] || ready[sel];
                chk("mon_o_ready", o_ready, er);
                chk("mon_o_valid", o_valid, mfull);
                nfull = mfull;
                for (int k = 0; k < 8; k++) begin
                    if (mfull[k] && ready[k]) begin
                        if (q[k].size() == 0) chk("mon_queue_empty", 1, 0);
                        else begin
                            w = q[k].pop_front();
                            chk("mon_drain_word", o_data[k*16 +: 16], w);
                        end
                        nfull[k] = 1'b0;
                    end
                end
                if (valid && er) begin
                    q[sel].push_back(data);
                    nfull[sel] = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mfull = '0;
            armed = 1'b1;
        end else if (armed) mfull = nfull;
    end

    initial begin
        logic [127:0] e;
        repeat (2) tick();
        chk("rst_o_valid", o_valid, 8'h00);
        chk("rst_o_count", o_count, 16'h0);
        chk("rst_o_ready", o_ready, 1'b1);
        chk("rst_o_data", o_data, 128'h0);
        rst_n = 1'b1;

        sel = 3'd5; data = 16'hBEEF; valid = 1'b1;
        tick();
        valid = 1'b0;
        e = '0; e[80 +: 16] = 16'hBEEF;
        chk("route_o_valid", o_valid, 8'h20);
        chk("route_o_data", o_data, e);
        chk("route_o_count", o_count, 16'd1);
        ready = 8'h20; tick(); ready = 8'h00;

        sel = 3'd2; data = 16'h1111; valid = 1'b1;
        tick();
        data = 16'h2222;
        #1 chk("bp_o_ready_low", o_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_word", o_data[32 +: 16], 16'h1111);
            chk("bp_hold_ready", o_ready, 1'b0);
        end
        ready = 8'h04;
        #1 chk("bp_o_ready_high", o_ready, 1'b1);
        tick();
        valid = 1'b0; ready = 8'h00;
        chk("bp_new_word", o_data[32 +: 16], 16'h2222);
        chk("bp_new_valid", o_valid[2], 1'b1);
        ready = 8'h04; tick(); ready = 8'h00;

        ready = 8'h08; sel = 3'd3; valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            data = 16'(i);
            #1 chk("stream_o_ready", o_ready, 1'b1);
            tick();
            chk("stream_word", o_data[48 +: 16], 16'(i));
            chk("stream_valid", o_valid[3], 1'b1);
        end
        valid = 1'b0;
        chk("stream_o_count", o_count, 16'd19);
        tick();
        chk("stream_valid_fall", o_valid[3], 1'b0);
        ready = 8'h00;

        for (int k = 0; k < 8; k++) begin
            sel = 3'(k); data = 16'h0A00 + 16'(k); valid = 1'b1;
            tick();
        end
        sel = 3'd0; data = 16'hCAFE; ready = 8'h52;
        #1 chk("cross_o_ready_low", o_ready, 1'b0);
        tick();
        chk("cross_o_valid", o_valid, 8'hAD);
        sel = 3'd4; ready = 8'h00;
        #1 chk("cross_o_ready_high", o_ready, 1'b1);
        tick();
        valid = 1'b0;
        chk("cross_word4", o_data[64 +: 16], 16'hCAFE);
        chk("cross_word0", o_data[0 +: 16], 16'h0A00);
        chk("cross_o_valid2", o_valid, 8'hBD);
        chk("cross_o_count", o_count, 16'd28);
        ready = 8'hFF; tick(); ready = 8'h00;
        chk("cross_drained", o_valid, 8'h00);

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("wrap_start_count", o_count, 16'h0);
        sel = 3'd3; ready = 8'h08; valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            data = 16'(i);
            tick();
        end
        chk("wrap_ffff", o_count, 16'hFFFF);
        tick();
        valid = 1'b0; ready = 8'h00;
        chk("wrap_zero", o_count, 16'h0000);

        sel = 3'd1; data = 16'h1001; valid = 1'b1; tick();
        sel = 3'd7; data = 16'h7007; tick();
        chk("pre_rst_valid", o_valid[7] & o_valid[1], 1'b1);
        rst_n = 1'b0; sel = 3'd1; data = 16'h5555; ready = 8'hFF;
        tick();
        rst_n = 1'b1; valid = 1'b0; ready = 8'h00;
        chk("midrst_o_valid", o_valid, 8'h00);
        chk("midrst_o_count", o_count, 16'h0);
        chk("midrst_o_data", o_data, 128'h0);
        tick();
        chk("midrst_no_capture", o_valid, 8'h00);
        chk("midrst_count_hold", o_count, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
